// File: rtl/pattern_generator_pkg.sv
// pattern_generator_pkg: shared sizes, FSM encoding and the fill-pointer priority encoder
package pattern_generator_pkg;
   localparam int NCHAN = 16;
   localparam int WORD_BITS = 16;
   typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDERRUN} state_t;
   function automatic logic [4:0] first_en(input logic [NCHAN-1:0] mask, input logic [4:0] from);
      first_en = 5'(NCHAN);
      for (int i = NCHAN - 1; i >= 0; i--)
         if (mask[i] && i >= int'(from)) first_en = 5'(i);
   endfunction
endpackage

// File: rtl/pattern_generator_parallel_to_serial.sv
// parallel_to_serial: one channel's load/shift register, LSB presented first
module parallel_to_serial
   import pattern_generator_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 shift,
   input  logic [WORD_BITS-1:0] din,
   output logic                 out
);
   logic [WORD_BITS-1:0] sreg_q, sreg_d;
   always_comb sreg_d = load ? din : shift ? {1'b0, sreg_q[WORD_BITS-1:1]} : sreg_q;
   always_ff @(posedge clk) begin
      if (rst) sreg_q <= '0;
      else     sreg_q <= sreg_d;
   end
   assign out = sreg_q[0];
endmodule

// File: rtl/pattern_generator.sv
// pattern_generator: fills a per-channel shadow bank from a word stream and shifts frames out serially
module pattern_generator
   import pattern_generator_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 gen_enable,
   input  logic [7:0]           clock_divisor,
   input  logic [NCHAN-1:0]     channel_enable,
   input  logic [WORD_BITS-1:0] word_data,
   input  logic                 word_valid,
   output logic                 word_ready,
   output logic [NCHAN-1:0]     probe_out,
   output logic [NCHAN-1:0]     probe_oe,
   output logic                 underrun
);
   if (NCHAN != 16 || WORD_BITS != 16) begin : g_bad_cfg
      $error("pattern_generator supports exactly 16 channels of 16-bit words");
   end

   state_t               state_q, state_d;
   logic                 gen_q, gen_d, full_q, full_d, und_q, und_d;
   logic [NCHAN-1:0]     en_q, en_d, oe_q, oe_d;
   logic [4:0]           ptr_q, ptr_d, eff, nxt;
   logic [7:0]           div_q, div_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [WORD_BITS-1:0] shadow_q [NCHAN];
   logic [WORD_BITS-1:0] shadow_d [NCHAN];
   logic                 clr, accept, last, full_now, tick, frame_end, transfer, shift, start;

   always_comb begin
      clr = rst | ~gen_enable;
      start = state_q == IDLE && !gen_q;
      eff = first_en(en_q, ptr_q);
      nxt = first_en(en_q, eff + 5'd1);
      word_ready = gen_enable && state_q != IDLE && eff != 5'(NCHAN);
      accept = word_valid & word_ready;
      last = accept && nxt == 5'(NCHAN);
      // the word completing the set may be shipped in the very cycle it arrives
      full_now = full_q | last;
      tick = div_q == 8'd0;
      frame_end = state_q == RUN && tick && cnt_q == 4'(WORD_BITS - 1);
      transfer = (state_q == PRIME && full_q) || (state_q == UNDERRUN && full_now) || (frame_end && full_now);
      shift = state_q == RUN && tick && !frame_end;
      for (int k = 0; k < NCHAN; k++)
         shadow_d[k] = clr ? '0 : (accept && eff == 5'(k)) ? word_data : shadow_q[k];
      state_d = clr ? IDLE : start ? PRIME : transfer ? RUN : frame_end ? UNDERRUN : state_q;
      gen_d = ~rst & gen_enable;
      en_d = clr ? '0 : start ? channel_enable : en_q;
      ptr_d = (clr || transfer) ? 5'd0 : accept ? eff + 5'd1 : ptr_q;
      full_d = (clr || transfer) ? 1'b0 : last ? 1'b1 : full_q;
      div_d = clr ? 8'd0 : transfer ? clock_divisor : state_q != RUN ? div_q : tick ? clock_divisor : div_q - 8'd1;
      cnt_d = (clr || transfer) ? 4'd0 : shift ? cnt_q + 4'd1 : cnt_q;
      und_d = ~clr & (und_q | (frame_end & ~full_now));
      oe_d = clr ? '0 : transfer ? en_q : oe_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gen_q <= 1'b0;
         full_q <= 1'b0;
         und_q <= 1'b0;
         en_q <= '0;
         oe_q <= '0;
         ptr_q <= '0;
         div_q <= '0;
         cnt_q <= '0;
         shadow_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         gen_q <= gen_d;
         full_q <= full_d;
         und_q <= und_d;
         en_q <= en_d;
         oe_q <= oe_d;
         ptr_q <= ptr_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   for (genvar g = 0; g < NCHAN; g++) begin : g_ch
      parallel_to_serial u_p2s (
         .clk   (clk),
         .rst   (clr),
         .load  (transfer),
         .shift (shift),
         .din   (shadow_d[g]),
         .out   (probe_out[g])
      );
   end

   assign probe_oe = oe_q;
   assign underrun = und_q;
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: table-driven vectors plus directed multi-cycle sequences
module tb_pattern_generator;
   logic        clk = 1'b0;
   logic        rst, gen_enable, word_valid, word_ready, underrun;
   logic [7:0]  clock_divisor;
   logic [15:0] channel_enable, word_data, probe_out, probe_oe;
   int tests = 0;
   int fails = 0;

   typedef struct {
      logic gen; logic [15:0] en; logic [7:0] div; logic [15:0] data; logic valid;
      logic rdy; logic [15:0] out; logic [15:0] oe; logic und;
   } vec_t;
   vec_t v[37];

   pattern_generator dut (
      .clk(clk), .rst(rst), .gen_enable(gen_enable), .clock_divisor(clock_divisor),
      .channel_enable(channel_enable), .word_data(word_data), .word_valid(word_valid),
      .word_ready(word_ready), .probe_out(probe_out), .probe_oe(probe_oe), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_clear(input string name);
      chk({name, " probe_out"}, probe_out, 16'h0);
      chk({name, " probe_oe"}, probe_oe, 16'h0);
      chk({name, " word_ready"}, {15'b0, word_ready}, 16'h0);
      chk({name, " underrun"}, {15'b0, underrun}, 16'h0);
   endtask

   initial begin
      logic [15:0] pat;
      int n;
      rst = 1'b1; gen_enable = 1'b0; clock_divisor = 8'd0; channel_enable = 16'h0;
      word_data = 16'h0; word_valid = 1'b0;
      for (int i = 0; i < 37; i++)
         v[i] = '{gen: 1'b1, en: 16'h0001, div: 8'd0, data: 16'h0, valid: 1'b0,
                  rdy: 1'b0, out: 16'h0, oe: 16'h0, und: 1'b0};
      v[0].gen = 1'b0;
      v[2].valid = 1'b1; v[2].data = 16'hA5A5; v[2].rdy = 1'b1;
      v[3].valid = 1'b1; v[3].data = 16'hFFFF;
      pat = 16'hA5A5;
      for (int i = 0; i < 16; i++) begin
         v[4+i].out = {15'b0, pat[i]};
         v[4+i].oe = 16'h0001;
      end
      v[4].valid = 1'b1; v[4].data = 16'hFFFF; v[4].rdy = 1'b1;
      for (int i = 20; i < 37; i++) begin
         v[i].out = 16'h0001; v[i].oe = 16'h0001; v[i].rdy = 1'b1;
      end
      v[36].und = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // single channel, divisor 0: A5A5 then FFFF back to back, then starve
      for (int i = 0; i < 37; i++) begin
         gen_enable = v[i].gen; channel_enable = v[i].en; clock_divisor = v[i].div;
         word_data = v[i].data; word_valid = v[i].valid;
         #1;
         chk($sformatf("vec%0d word_ready", i), {15'b0, word_ready}, {15'b0, v[i].rdy});
         chk($sformatf("vec%0d probe_out", i), probe_out, v[i].out);
         chk($sformatf("vec%0d probe_oe", i), probe_oe, v[i].oe);
         chk($sformatf("vec%0d underrun", i), {15'b0, underrun}, {15'b0, v[i].und});
         @(posedge clk);
         #1;
      end

      // underrun: second frame withheld, then supplied late
      gen_enable = 1'b0;
      cyc();
      chk_clear("disable_from_underrun");
      gen_enable = 1'b1; channel_enable = 16'h0003; clock_divisor = 8'd1;
      cyc();
      word_valid = 1'b1; word_data = 16'h8001;
      cyc();
      word_data = 16'hC002;
      cyc();
      word_valid = 1'b0;
      cyc();
      chk("ur bit0 out", probe_out, 16'h0001);
      chk("ur bit0 oe", probe_oe, 16'h0003);
      repeat (29) cyc();
      chk("ur bit14 out", probe_out, 16'h0002);
      repeat (2) cyc();
      chk("ur bit15 out", probe_out, 16'h0003);
      chk("ur bit15 underrun", {15'b0, underrun}, 16'h0);
      cyc();
      chk("ur hold out", probe_out, 16'h0003);
      chk("ur hold oe", probe_oe, 16'h0003);
      chk("ur flag set", {15'b0, underrun}, 16'h1);
      chk("ur ready", {15'b0, word_ready}, 16'h1);
      repeat (5) cyc();
      chk("ur hold later", probe_out, 16'h0003);
      word_valid = 1'b1; word_data = 16'h0002;
      cyc();
      chk("ur hold mid-fill", probe_out, 16'h0003);
      word_data = 16'h0001;
      cyc();
      word_valid = 1'b0;
      chk("ur restart bit0", probe_out, 16'h0002);
      chk("ur restart underrun sticky", {15'b0, underrun}, 16'h1);
      cyc();
      chk("ur restart bit0 2nd cycle", probe_out, 16'h0002);
      cyc();
      chk("ur restart bit1", probe_out, 16'h0001);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_clear("rst_mid_frame");

      // backpressure with valid held high, two channels
      gen_enable = 1'b0;
      cyc();
      gen_enable = 1'b1; channel_enable = 16'h0003; clock_divisor = 8'd1;
      word_valid = 1'b1; word_data = 16'hAAAA;
      cyc();
      chk("bp prime0 ready", {15'b0, word_ready}, 16'h1);
      cyc();
      chk("bp prime1 ready", {15'b0, word_ready}, 16'h1);
      cyc();
      chk("bp prime full ready", {15'b0, word_ready}, 16'h0);
      cyc();
      chk("bp run0 ready", {15'b0, word_ready}, 16'h1);
      chk("bp run0 oe", probe_oe, 16'h0003);
      cyc();
      chk("bp run1 ready", {15'b0, word_ready}, 16'h1);
      cyc();
      chk("bp run2 ready", {15'b0, word_ready}, 16'h0);
      n = 0;
      repeat (29) begin
         cyc();
         if (word_ready) n++;
      end
      chk("bp ready cycles before boundary", 16'(n), 16'h0);
      cyc();
      chk("bp ready after boundary", {15'b0, word_ready}, 16'h1);
      chk("bp no underrun", {15'b0, underrun}, 16'h0);
      word_valid = 1'b0;
      repeat (3) cyc();
      gen_enable = 1'b0;
      cyc();
      chk_clear("disable_mid_frame");

      // three channels with divisor 3 and a fresh mask
      gen_enable = 1'b1; channel_enable = 16'h8005; clock_divisor = 8'd3;
      cyc();
      word_valid = 1'b1; word_data = 16'h0001;
      cyc();
      word_data = 16'h0002;
      cyc();
      word_data = 16'h8000;
      cyc();
      word_valid = 1'b0;
      chk("mc full ready", {15'b0, word_ready}, 16'h0);
      cyc();
      for (int b = 0; b < 16; b++)
         for (int c = 0; c < 4; c++) begin
            pat = (b == 0) ? 16'h0001 : (b == 1) ? 16'h0004 : (b == 15) ? 16'h8000 : 16'h0000;
            chk($sformatf("mc bit%0d c%0d out", b, c), probe_out, pat);
            chk($sformatf("mc bit%0d c%0d oe", b, c), probe_oe, 16'h8005);
            cyc();
         end

      // empty channel mask
      gen_enable = 1'b0;
      cyc();
      gen_enable = 1'b1; channel_enable = 16'h0000; clock_divisor = 8'd0;
      word_valid = 1'b1; word_data = 16'h1234;
      for (int i = 0; i < 100; i++) begin
         cyc();
         chk_clear($sformatf("zero_mask c%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pattern_generator.md
Name: pattern_generator

Overview:
- Output-direction counterpart of the capture path.
- Accepts a stream of 16-bit words (one word per enabled channel per frame, lowest channel first) and shifts each word out serially on its channel's probe output.
- Shifting runs at the sample rate set by clock_divisor.
- Sits in the fast clock domain, fed from the host-side word FIFO; drives the probe pad output and output-enable signals.

Parameters:
- NCHAN, 16, number of channels (fixed at 16; elaboration error otherwise).
- WORD_BITS, 16, bits per channel word; also bits per frame.

Ports:
- clk  in  1  fast domain clock.
- rst  in  1  synchronous reset, active-high.
- gen_enable  in  1  run enable; deassertion aborts and returns to IDLE.
- clock_divisor  in  8  bit period = clock_divisor+1 clk cycles.
- channel_enable  in  16  per-channel enable; latched on the gen_enable rising edge.
- word_data  in  16  next channel word; bit 0 is sent first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  block accepts a word this cycle.
- probe_out  out  16  serial data per channel (registered).
- probe_oe  out  16  output enable per channel (registered).
- underrun  out  1  sticky; a frame boundary was reached with no complete next frame.

Behaviour:
- Reset values:
  - word_ready=0, probe_out=0, probe_oe=0, underrun=0.
  - State IDLE; shadow registers and shift registers cleared; fill pointer cleared.
- Enable and disable:
  - On the gen_enable 0->1 edge, latch channel_enable to en_q and go to PRIME.
  - gen_enable=0 in any state: next cycle go to IDLE, clear everything as at reset (rst has priority).
  - If en_q==0: stay in PRIME with word_ready=0; outputs stay 0. Not an error.
- Fill (PRIME, RUN, UNDERRUN):
  - The shadow bank holds one word per channel; the fill pointer is the lowest enabled channel not yet loaded.
  - word_ready=1 while the shadow set is incomplete and gen_enable=1.
  - On word_valid&word_ready: shadow[ptr]<=word_data and ptr advances to the next enabled channel.
  - After the highest enabled channel is loaded, shadow_full<=1 and word_ready drops the next cycle.
  - Disabled channels consume no words.
- PRIME -> RUN:
  - In the first cycle with shadow_full=1, transfer shadow to shift registers, clear shadow_full, reset ptr, clear bit_cnt and the divider.
  - probe_out[i]=word bit 0 and probe_oe=en_q take effect the cycle after transfer.
- RUN:
  - The divider pulses tick every clock_divisor+1 cycles, counted from transfer. clock_divisor=0 gives a tick every cycle.
  - On tick with bit_cnt<15: shift right, bit_cnt+1; probe_out updates the next cycle.
  - On tick with bit_cnt==15 and shadow_full=1: transfer the next frame seamlessly, with no extra cycle.
  - On tick with bit_cnt==15 and shadow_full=0: underrun<=1, go to UNDERRUN.
  - A word accepted in the same cycle that completes the shadow set counts as shadow_full for that tick.
- UNDERRUN:
  - probe_out holds the last bit and probe_oe stays asserted.
  - Filling continues. When shadow_full, transfer as in PRIME and return to RUN.
  - underrun stays 1 until IDLE.
- Disabled channels: probe_out=0, probe_oe=0 at all times.
- clock_divisor: may change in any state; takes effect at the next divider reload.
- Throughput: one word per clk cycle. The frame period is 16*(clock_divisor+1) cycles, so the upstream source must provide popcount(en_q) words within it.

Decomposition:
- Shared package: NCHAN, WORD_BITS, state encoding (IDLE, PRIME, RUN, UNDERRUN).
- Sub-module parallel_to_serial (one per channel, generate loop) holds the load/shift register; inputs clk, rst, load, shift, din[15:0]; output out.
- The divider, bit counter, fill pointer (priority encoder over en_q above ptr) and FSM stay in the top level.

Test Plan:
- en=16'h0001, div=0, word 16'hA5A5 then 16'hFFFF: probe_out[0] shows 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 one cycle per bit, then 16 ones back-to-back with no gap; underrun=0.
- en=16'h8005, div=3, frame words 0x0001, 0x0002, 0x8000: map to channels 0, 2, 15. Each bit lasts 4 cycles; ch0 is high for bit 0 only, ch2 for bit 1 only, ch15 for bit 15 only. probe_oe=0x8005 throughout.
- en=16'h0003, div=1, first frame loaded, second frame withheld:
  - At the bit_cnt==15 tick, underrun goes to 1 and outputs hold bit 15.
  - Supply the frame later: outputs restart at bit 0 the cycle after the last word is accepted; underrun stays 1.
- word_valid held high with 2 channels enabled during RUN: word_ready deasserts after exactly 2 accepted words and reasserts the cycle after the frame boundary transfer.
- Mid-frame gen_enable deassert, and separately rst: next cycle probe_out=0, probe_oe=0, word_ready=0, underrun=0. Re-enable with a new channel_enable; the new mask is used.
- gen_enable 0->1 with channel_enable=0: word_ready stays 0, outputs stay 0, no underrun over 100 cycles.
